// File: rtl/booth_mul_arbiter.sv
// Round-robin front end sharing one Booth multiplier among 2**ID_W requesters.
// Latency: grant -> load pulse next cycle -> RUN until mul_fin -> registered response.
// Backpressure: one job in flight; no grant until the response handshake completes.
// Optional build macro BOOTH_ARB_TIMEOUT_EN aborts a RUN that lasts TIMEOUT cycles.
module booth_mul_arbiter #(
  parameter int W       = 3,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [(2**ID_W)-1:0]     req_valid,
  output logic [(2**ID_W)-1:0]     req_ready,
  input  logic [(2**ID_W)*W-1:0]   req_q,
  input  logic [(2**ID_W)*W-1:0]   req_m,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*W-1:0]           rsp_result,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [W-1:0]             mul_q,
  output logic [W-1:0]             mul_m,
  output logic                     mul_load,
  input  logic                     mul_fin,
  input  logic [2*W-1:0]           mul_result
);

  localparam int N_REQ = 2**ID_W;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   idx;
  logic [N_REQ-1:0]  win_oh;
  logic              found;

  // Scan requesters starting at ptr; the first valid one wins.
  always_comb begin
    win_oh = '0;
    win_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + ID_W'(k);
      if (!found && req_valid[idx]) begin
        found       = 1'b1;
        win_id      = idx;
        win_oh[idx] = 1'b1;
      end
    end
  end

  // A grant during reset would be lost, so the ready is masked while reset is low.
  assign req_ready = (reset && state == IDLE) ? win_oh : '0;

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] run_cnt;
  logic          err_q;
  assign rsp_err = err_q;
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = TIMEOUT;
  assign rsp_err        = 1'b0;
`endif

  // Job sequencer: grant/latch, load pulse, wait for fin, hold response until accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      mul_q      <= '0;
      mul_m      <= '0;
      mul_load   <= 1'b0;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
      run_cnt    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      mul_load <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            mul_q    <= req_q[win_id*W +: W];
            mul_m    <= req_m[win_id*W +: W];
            rsp_id   <= win_id;
            mul_load <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
`ifdef BOOTH_ARB_TIMEOUT_EN
          run_cnt <= '0;
`endif
          state <= RUN;
        end
        RUN: begin
          // A fin that coincides with the last allowed cycle still returns the real product.
          if (mul_fin) begin
            rsp_result <= mul_result;
            rsp_valid  <= 1'b1;
`ifdef BOOTH_ARB_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            state      <= DONE;
          end
`ifdef BOOTH_ARB_TIMEOUT_EN
          else if (run_cnt == CW'(TIMEOUT - 1)) begin
            rsp_result <= '0;
            rsp_valid  <= 1'b1;
            err_q      <= 1'b1;
            state      <= DONE;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            ptr       <= rsp_id + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: directed vector table, reset/timeout sequences and random jobs.
// A behavioural multiplier answers mul_load after a programmable number of cycles (0 = never).
// Expected grants and products come from a round-robin/arithmetic reference model.
module tb_booth_mul_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_q, req_m;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [5:0]  rsp_result;
  logic        rsp_err, busy;
  logic [2:0]  mul_q, mul_m;
  logic        mul_load;
  logic        mul_fin;
  logic [5:0]  mul_result;

  int n_chk  = 0;
  int n_fail = 0;
  int ptr_model = 0;
  int fin_dly = 1;
  int mcnt = 0;
  logic [5:0] mres;

  booth_mul_arbiter #(.W(3), .ID_W(2), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_q(req_q), .req_m(req_m),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
    .mul_q(mul_q), .mul_m(mul_m), .mul_load(mul_load),
    .mul_fin(mul_fin), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  function automatic int sx(input logic [2:0] v);
    return v[2] ? int'(v) - 8 : int'(v);
  endfunction

  function automatic int arb(input int p, input logic [3:0] mask);
    for (int k = 0; k < 4; k++)
      if (mask[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // Behavioural multiplier: fin rises fin_dly cycles after the load cycle and stays high.
  always @(negedge clk) begin
    if (!reset) begin
      mul_fin = 1'b0;
      mcnt    = 0;
    end else if (mul_load) begin
      mul_fin    = 1'b0;
      mcnt       = fin_dly;
      mres       = 6'(sx(mul_q) * sx(mul_m));
      mul_result = 6'($urandom);
    end else if (mcnt > 0) begin
      mcnt = mcnt - 1;
      if (mcnt == 0) begin
        mul_fin    = 1'b1;
        mul_result = mres;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete job; called at a negedge while the DUT is idle.
  task automatic do_job(input logic [3:0] mask, input logic [11:0] qv, input logic [11:0] mv,
                        input int dly, input int stall, input int eid, input logic [5:0] eres);
    int   n;
    int   lat;
    logic eerr;
    logic quiet_bad;
    eerr = (dly == 0);
    lat  = (dly == 0) ? 17 : dly + 1;
    req_valid = mask;
    req_q     = qv;
    req_m     = mv;
    fin_dly   = dly;
    #1;
    check("grant_onehot", req_ready, 64'(4'b0001 << eid));
    @(negedge clk);
    check("load_pulse", {mul_load, busy, req_ready}, {1'b1, 1'b1, 4'b0000});
    check("mul_operands", {mul_q, mul_m}, {qv[eid*3 +: 3], mv[eid*3 +: 3]});
    n = 0;
    quiet_bad = 1'b0;
    while (!rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
      if (mul_load || req_ready != 4'b0 || !busy) quiet_bad = 1'b1;
    end
    check("run_quiet", quiet_bad, 1'b0);
    check("latency", n, lat);
    check("rsp_fields", {rsp_valid, rsp_id, rsp_result, rsp_err},
          {1'b1, 2'(eid), eres, eerr});
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_hold", {rsp_valid, rsp_id, rsp_result, rsp_err, req_ready, busy},
            {1'b1, 2'(eid), eres, eerr, 4'b0000, 1'b1});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("handshake_clear", {rsp_valid, busy}, 2'b00);
    ptr_model = (eid + 1) % 4;
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [11:0] q;
    logic [11:0] m;
    int          dly;
    int          stall;
    int          id;
    logic [5:0]  res;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  mask;
    logic [11:0] qv, mv;
    int          eid, bad;

    tbl[0] = '{4'b0001, 12'o0003, 12'o0002, 4, 0, 0, 6'd6};
    tbl[1] = '{4'b0100, 12'o0700, 12'o0300, 3, 0, 2, 6'o75};
    tbl[2] = '{4'b1111, 12'o4321, 12'o3333, 1, 0, 0, 6'd3};
    tbl[3] = '{4'b1111, 12'o4321, 12'o3333, 2, 0, 1, 6'd6};
    tbl[4] = '{4'b1111, 12'o4321, 12'o3333, 1, 0, 2, 6'd9};
    tbl[5] = '{4'b1111, 12'o4321, 12'o3333, 3, 0, 3, 6'd52};
    tbl[6] = '{4'b1111, 12'o4321, 12'o3333, 1, 0, 0, 6'd3};
    tbl[7] = '{4'b1111, 12'o4321, 12'o3333, 2, 5, 1, 6'd6};
    tbl[8] = '{4'b1000, 12'o4321, 12'o3333, 16, 0, 3, 6'd52};
    tbl[9] = '{4'b0010, 12'o0070, 12'o0070, 1, 1, 1, 6'd1};

    reset = 1'b0; req_valid = '0; req_q = '0; req_m = '0; rsp_ready = 1'b0;
    mul_result = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, busy,
                            mul_q, mul_m, mul_load}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 2; i++)
      do_job(tbl[i].mask, tbl[i].q, tbl[i].m, tbl[i].dly, tbl[i].stall, tbl[i].id, tbl[i].res);

    // Reset in the middle of RUN drops the job; arbitration restarts at requester 0.
    req_valid = 4'b1111; fin_dly = 0;
    #1;
    check("pre_reset_grant", req_ready, 4'b1000);
    @(negedge clk);
    req_valid = 4'b0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun_reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, busy,
                                   mul_q, mul_m, mul_load}, 64'd0);
    reset = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid || busy) bad++;
    end
    check("dropped_job_silent", bad, 0);
    ptr_model = 0;

    for (int i = 2; i < 10; i++)
      do_job(tbl[i].mask, tbl[i].q, tbl[i].m, tbl[i].dly, tbl[i].stall, tbl[i].id, tbl[i].res);

    for (int r = 0; r < 25; r++) begin
      mask = 4'($urandom_range(1, 15));
      qv   = 12'($urandom);
      mv   = 12'($urandom);
      eid  = arb(ptr_model, mask);
      do_job(mask, qv, mv, $urandom_range(1, 8), $urandom_range(0, 3), eid,
             6'(sx(qv[eid*3 +: 3]) * sx(mv[eid*3 +: 3])));
    end

`ifdef BOOTH_ARB_TIMEOUT_EN
    eid = arb(ptr_model, 4'b1111);
    do_job(4'b1111, 12'o1234, 12'o5671, 0, 2, eid, 6'd0);
`else
    eid = arb(ptr_model, 4'b1111);
    req_valid = 4'b1111; fin_dly = 0;
    #1;
    check("hang_grant", req_ready, 64'(4'b0001 << eid));
    @(negedge clk);
    req_valid = 4'b0000;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (!busy || rsp_valid) bad++;
    end
    check("no_timeout_busy", bad, 0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
